muldiv_sequencer: RTL and testbench



---
 rtl/muldiv_sequencer.sv | 158 +++++++++++++++
 tb/tb_muldiv_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M multiply/divide sequencer. It sits beside the single-cycle
// ALU in EX and stalls the pipeline while an iterative shift-add multiply or
// restoring divide runs for XLEN cycles.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for an M-extension instruction in EX
// CALC   | XLEN iterations of shift-add multiply or restoring divide
// FIX    | sign correction and half/quotient/remainder selection
// DONE   | Result valid, done pulses, pipeline released
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [1:0]      ALUOp,
  input  logic [6:0]      Funct7,
  input  logic [2:0]      Funct3,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  input  logic            flush,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] Result
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q;
  logic [2*XLEN-1:0]   acc_q;
  logic [XLEN-1:0]     b_mag_q;
  logic [2:0]          f3_q;
  logic                a_neg_q, b_neg_q;
  logic [XLEN-1:0]     result_q, result_d;

  logic                accept, fast;
  logic                is_div_in, a_sgn_in, b_sgn_in, a_neg_in, b_neg_in;
  logic [XLEN-1:0]     a_mag_in, b_mag_in, fast_result;
  logic                div_zero, div_ovf;
  logic [2*XLEN-1:0]   acc_step, prod, prod_s;
  logic [XLEN:0]       mul_sum, div_shift, div_diff;
  logic                div_ge;
  logic [XLEN-1:0]     quo_s, rem_s, fix_result;

  // Decode the incoming instruction, operand signedness and divide special cases.
  always_comb begin
    accept    = (state_q == S_IDLE) && start && (ALUOp == 2'b10) &&
                (Funct7 == 7'b0000001) && !flush;
    is_div_in = Funct3[2];
    // DIV/REM are signed, DIVU/REMU unsigned; MULHU is the only fully unsigned multiply
    // and only MUL/MULH treat rs2 as signed.
    a_sgn_in  = is_div_in ? ~Funct3[0] : (Funct3 != 3'b011);
    b_sgn_in  = is_div_in ? ~Funct3[0] : (Funct3[2:1] == 2'b00);
    a_neg_in  = a_sgn_in & SrcA[XLEN-1];
    b_neg_in  = b_sgn_in & SrcB[XLEN-1];
    a_mag_in  = a_neg_in ? (~SrcA + 1'b1) : SrcA;
    b_mag_in  = b_neg_in ? (~SrcB + 1'b1) : SrcB;
    div_zero  = is_div_in && (SrcB == '0);
    div_ovf   = is_div_in && !Funct3[0] && (SrcA == {1'b1, {(XLEN-1){1'b0}}}) &&
                (SrcB == '1);
    fast      = div_zero || div_ovf;
    if (div_zero) fast_result = Funct3[1] ? SrcA : '1;
    else          fast_result = Funct3[1] ? '0 : SrcA;
  end

  // One iteration of either algorithm; acc holds {hi, lo}, lo starts as rs1 magnitude.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_mag_q} : '0);
    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, b_mag_q};
    div_ge    = !div_diff[XLEN];
    if (f3_q[2])
      acc_step = {(div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]),
                  acc_q[XLEN-2:0], div_ge};
    else
      acc_step = {mul_sum, acc_q[XLEN-1:1]};
  end

  // Sign correction and selection of the architectural result in FIX.
  always_comb begin
    prod   = acc_q;
    prod_s = (a_neg_q ^ b_neg_q) ? (~prod + 1'b1) : prod;
    quo_s  = (a_neg_q ^ b_neg_q) ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
    rem_s  = a_neg_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];
    if (f3_q[2])               fix_result = f3_q[1] ? rem_s : quo_s;
    else if (f3_q[1:0] == 2'b00) fix_result = prod_s[XLEN-1:0];
    else                       fix_result = prod_s[2*XLEN-1:XLEN];
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; flush aborts CALC/FIX but never a pending DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = fast ? S_DONE : S_CALC;
      S_CALC: begin
        if (flush)                          state_d = S_IDLE;
        else if (cnt_q == CW'(XLEN - 1))    state_d = S_FIX;
      end
      S_FIX:  state_d = flush ? S_IDLE : S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state; stall also covers the accept cycle itself.
  always_comb begin
    busy  = (state_q != S_IDLE);
    stall = accept || (state_q == S_CALC) || (state_q == S_FIX);
    done  = (state_q == S_DONE);
  end

  // Result is only loaded on the transition into DONE.
  always_comb begin
    result_d = result_q;
    if (state_d == S_DONE && state_q != S_DONE)
      result_d = (state_q == S_IDLE) ? fast_result : fix_result;
  end

  // Operand latch, iteration counter and accumulator.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      b_mag_q  <= '0;
      f3_q     <= '0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      result_q <= '0;
    end else begin
      result_q <= result_d;
      if (accept) begin
        cnt_q   <= '0;
        acc_q   <= {{XLEN{1'b0}}, a_mag_in};
        b_mag_q <= b_mag_in;
        f3_q    <= Funct3;
        a_neg_q <= a_neg_in;
        b_neg_q <= b_neg_in;
      end else if (state_q == S_CALC) begin
        cnt_q <= cnt_q + 1'b1;
        acc_q <= acc_step;
      end
    end
  end

  assign Result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [1:0]  ALUOp;
  logic [6:0]  Funct7;
  logic [2:0]  Funct3;
  logic [31:0] SrcA, SrcB;
  logic        flush;
  logic        busy, stall, done;
  logic [31:0] Result;

  int tests_run = 0;
  int tests_failed = 0;

  muldiv_sequencer #(.XLEN(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .ALUOp(ALUOp), .Funct7(Funct7),
    .Funct3(Funct3), .SrcA(SrcA), .SrcB(SrcB), .flush(flush), .busy(busy),
    .stall(stall), .done(done), .Result(Result)
  );

  always #5 clk = ~clk;

  // Issue one M instruction in the current cycle, wait for done (bounded),
  // report latency, Result and whether done was still high one cycle later.
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic [31:0] res, output logic done_next);
    start = 1'b1; ALUOp = 2'b10; Funct7 = 7'b0000001; Funct3 = f3; SrcA = a; SrcB = b;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    res = Result;
    @(posedge clk); #1;
    done_next = done;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; ALUOp = 2'b00; Funct7 = 7'd0; Funct3 = 3'd0;
    SrcA = 32'd0; SrcB = 32'd0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({busy, stall, done} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_flags: busy/stall/done=%b required 000", {busy, stall, done});
    end
    tests_run++;
    if (Result !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_result: got %h required 00000000", Result);
    end
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mul_latency();
    int done_cnt = 0, first_done = 0, stall_bad = 0;
    logic busy1 = 1'b0, busy35 = 1'b1;
    logic [31:0] res = 32'd0;
    start = 1'b1; ALUOp = 2'b10; Funct7 = 7'b0000001; Funct3 = 3'b000;
    SrcA = 32'd7; SrcB = 32'hFFFF_FFFD;
    #1;
    tests_run++;
    if (stall !== 1'b1) begin
      tests_failed++;
      $display("FAIL mul_stall_accept: got %b required 1", stall);
    end
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 35; c++) begin
      if (c <= 33 && stall !== 1'b1) stall_bad++;
      if (c >= 34 && stall !== 1'b0) stall_bad++;
      if (done === 1'b1) begin
        done_cnt++;
        if (first_done == 0) first_done = c;
        res = Result;
      end
      if (c == 1)  busy1 = busy;
      if (c == 35) busy35 = busy;
      if (c < 35) begin @(posedge clk); #1; end
    end
    tests_run++;
    if (stall_bad != 0) begin
      tests_failed++;
      $display("FAIL mul_stall_window: %0d bad cycles required 0", stall_bad);
    end
    tests_run++;
    if (first_done != 34 || done_cnt != 1) begin
      tests_failed++;
      $display("FAIL mul_done_timing: first at T+%0d count %0d required T+34 count 1",
               first_done, done_cnt);
    end
    tests_run++;
    if (res !== 32'hFFFF_FFEB) begin
      tests_failed++;
      $display("FAIL mul_result: got %h required ffffffeb", res);
    end
    tests_run++;
    if (busy1 !== 1'b1 || busy35 !== 1'b0) begin
      tests_failed++;
      $display("FAIL mul_busy: T+1=%b T+35=%b required 1 and 0", busy1, busy35);
    end
  endtask

  task automatic test_mul_variants();
    logic [2:0]  f3 [3] = '{3'b001, 3'b011, 3'b010};
    logic [31:0] va [3] = '{32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [31:0] vb [3] = '{32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [31:0] ve [3] = '{32'h4000_0000, 32'h4000_0000, 32'hFFFF_FFFF};
    int lat; logic [31:0] res; logic dn;
    for (int i = 0; i < 3; i++) begin
      do_op(f3[i], va[i], vb[i], lat, res, dn);
      tests_run++;
      if (res !== ve[i] || lat != 34 || dn !== 1'b0) begin
        tests_failed++;
        $display("FAIL mulh_f3_%b: result %h lat %0d done_after %b required %h lat 34 done_after 0",
                 f3[i], res, lat, dn, ve[i]);
      end
    end
  endtask

  task automatic test_div();
    logic [2:0]  f3 [4] = '{3'b100, 3'b110, 3'b101, 3'b111};
    logic [31:0] va [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
    logic [31:0] vb [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
    logic [31:0] ve [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
    int lat; logic [31:0] res; logic dn;
    for (int i = 0; i < 4; i++) begin
      do_op(f3[i], va[i], vb[i], lat, res, dn);
      tests_run++;
      if (res !== ve[i] || lat != 34 || dn !== 1'b0) begin
        tests_failed++;
        $display("FAIL div_f3_%b: result %h lat %0d done_after %b required %h lat 34 done_after 0",
                 f3[i], res, lat, dn, ve[i]);
      end
    end
  endtask

  task automatic test_flush();
    int c, lat; logic [31:0] res; logic dn;
    start = 1'b1; ALUOp = 2'b10; Funct7 = 7'b0000001; Funct3 = 3'b000;
    SrcA = 32'd123; SrcB = 32'd456;
    @(posedge clk); #1;
    start = 1'b0;
    c = 1;
    while (c < 10) begin @(posedge clk); #1; c++; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    tests_run++;
    if ({busy, stall, done} !== 3'b000) begin
      tests_failed++;
      $display("FAIL flush_abort: busy/stall/done=%b at T+11 required 000", {busy, stall, done});
    end
    @(posedge clk); #1;
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b0 || Result !== 32'd2) begin
      tests_failed++;
      $display("FAIL flush_quiet: done %b busy %b result %h at T+12 required 0 0 00000002",
               done, busy, Result);
    end
    do_op(3'b000, 32'd6, 32'd7, lat, res, dn);
    tests_run++;
    if (res !== 32'd42 || lat != 34) begin
      tests_failed++;
      $display("FAIL flush_restart: result %h lat %0d required 0000002a lat 34", res, lat);
    end
  endtask

  task automatic test_special();
    logic [2:0]  f3 [4] = '{3'b101, 3'b110, 3'b100, 3'b110};
    logic [31:0] va [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] vb [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] ve [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    int lat; logic [31:0] res; logic dn;
    for (int i = 0; i < 4; i++) begin
      do_op(f3[i], va[i], vb[i], lat, res, dn);
      tests_run++;
      if (res !== ve[i] || lat != 1 || dn !== 1'b0) begin
        tests_failed++;
        $display("FAIL special_%0d: result %h lat %0d done_after %b required %h lat 1 done_after 0",
                 i, res, lat, dn, ve[i]);
      end
    end
  endtask

  task automatic test_flush_accept_conflict();
    start = 1'b1; ALUOp = 2'b10; Funct7 = 7'b0000001; Funct3 = 3'b000;
    SrcA = 32'd3; SrcB = 32'd3; flush = 1'b1;
    #1;
    tests_run++;
    if (stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL conflict_stall: got %b required 0", stall);
    end
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL conflict_busy: got %b required 0", busy);
    end
  endtask

  task automatic test_reset_mid_op();
    int lat; logic [31:0] res; logic dn;
    do_op(3'b101, 32'd100, 32'd7, lat, res, dn);
    start = 1'b1; ALUOp = 2'b10; Funct7 = 7'b0000001; Funct3 = 3'b100;
    SrcA = 32'd1000; SrcB = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    tests_run++;
    if (busy !== 1'b1 || Result !== 32'd14) begin
      tests_failed++;
      $display("FAIL pre_reset: busy %b result %h required 1 0000000e", busy, Result);
    end
    reset_n = 1'b0;
    #1;
    tests_run++;
    if ({busy, stall, done} !== 3'b000 || Result !== 32'd0) begin
      tests_failed++;
      $display("FAIL mid_reset: busy/stall/done=%b result %h required 000 00000000",
               {busy, stall, done}, Result);
    end
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; ALUOp = 2'b10; Funct7 = 7'b0000000; Funct3 = 3'b000;
    SrcA = 32'd1; SrcB = 32'd2;
    #1;
    tests_run++;
    if (stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL add_stall: got %b required 0", stall);
    end
    @(posedge clk); #1;
    start = 1'b0;
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL add_busy: got %b required 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_mul_latency();
    test_mul_variants();
    test_div();
    test_flush();
    test_special();
    test_flush_accept_conflict();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
